// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and compositor layer bit indices for game_sequencer
package game_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;
  localparam int LAYER_BOARD = 0;
  localparam int LAYER_BUL1 = 1;
  localparam int LAYER_BUL2 = 2;
  localparam int LAYER_PLAYER = 3;
endpackage

// File: rtl/frame_strobe.sv
// frame_strobe: one-cycle frame tick when vcount returns to line 0
module frame_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vcount,
  output logic       tick
);
  logic [9:0] vprev;
  always_ff @(posedge clk)
    vprev <= !rst ? '0 : vcount;
  assign tick = vcount == '0 && vprev != '0;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: lives/invulnerability/game-over sequencer driving compositor layers; GAME_BLINK_EN blinks the player while invulnerable
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES            = 3,
  parameter int INVULN_FRAMES    = 60,
  parameter int OVER_HOLD_FRAMES = 120,
  parameter int BLINK_SHIFT      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vcount,
  input  logic       start,
  input  logic       hit1,
  input  logic       hit2,
  output logic       over,
  output logic [3:0] layer_en,
  output logic [2:0] lives,
  output logic       playing
);
  localparam logic [3:0] BOARD_BIT  = 4'(1 << LAYER_BOARD);
  localparam logic [3:0] PLAYER_BIT = 4'(1 << LAYER_PLAYER);
  localparam logic [3:0] ALL_ON     = BOARD_BIT | 4'(1 << LAYER_BUL1) | 4'(1 << LAYER_BUL2) | PLAYER_BIT;
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] INV_INIT   = 8'(INVULN_FRAMES);
  localparam logic [7:0] HOLD_MAX   = 8'(OVER_HOLD_FRAMES);
  state_t     state, state_d;
  logic [2:0] lives_d;
  logic [7:0] inv, inv_d, hold, hold_d;
  logic       start_q, start_qq, start_edge, tick, hit, player_on;
  logic [3:0] layer_d;
  frame_strobe u_frame_strobe (
    .clk    (clk),
    .rst    (rst),
    .vcount (vcount),
    .tick   (tick)
  );
  assign start_edge = start_q & ~start_qq;
  assign hit        = hit1 | hit2;
`ifdef GAME_BLINK_EN
  logic [7:0] fc, fc_d;
  assign fc_d      = (state_d == HIT && state != HIT) ? '0 : (state == HIT && tick) ? fc + 8'd1 : fc;
  assign player_on = ~fc_d[BLINK_SHIFT];
  always_ff @(posedge clk)
    fc <= !rst ? '0 : fc_d;
`else
  assign player_on = 1'b1;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state    <= IDLE;
      lives    <= LIVES_INIT;
      inv      <= '0;
      hold     <= '0;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      over     <= 1'b0;
      layer_en <= BOARD_BIT;
      playing  <= 1'b0;
    end else begin
      state    <= state_d;
      lives    <= lives_d;
      inv      <= inv_d;
      hold     <= hold_d;
      start_q  <= start;
      start_qq <= start_q;
      over     <= state_d == OVER;
      layer_en <= layer_d;
      playing  <= state_d == PLAY || state_d == HIT;
    end
  always_comb begin
    state_d = state;
    lives_d = lives;
    inv_d   = inv;
    hold_d  = hold;
    case (state)
      IDLE:
        if (start_edge) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
        end
      PLAY:
        if (hit) begin
          lives_d = lives - 3'd1;
          state_d = lives == 3'd1 ? OVER : HIT;
          hold_d  = lives == 3'd1 ? 8'd0 : hold;
          inv_d   = lives == 3'd1 ? inv : INV_INIT;
        end
      HIT:
        if (tick) begin
          inv_d   = inv - 8'd1;
          state_d = inv == 8'd1 ? PLAY : HIT;
        end
      OVER: begin
        hold_d = (tick && hold < HOLD_MAX) ? hold + 8'd1 : hold;
        if (start_edge && hold >= HOLD_MAX) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
        end
      end
      default: state_d = IDLE;
    endcase
    layer_d = state_d == IDLE ? BOARD_BIT :
              state_d == PLAY ? ALL_ON :
              state_d == HIT  ? (player_on ? ALL_ON : ALL_ON & ~PLAYER_BIT) : 4'b0000;
  end
endmodule
